// File: rtl/alu_pkg.sv
// Shared opcode constants, iterative-unit mode codes and FSM state encoding
// for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SAR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12;
  localparam logic [3:0] OP_DEC = 4'd13;
  localparam logic [3:0] OP_MUL = 4'd14;
  localparam logic [3:0] OP_DIV = 4'd15;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MUL_RUN = 2'd1;
  localparam state_t ST_DIV_RUN = 2'd2;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// done and {hi, lo} are combinational: they describe the result of the final step.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          run_q, run_d;
  logic          mode_q, mode_d;
  logic [N-1:0]  acc_hi_q, acc_hi_d;
  logic [N-1:0]  acc_lo_q, acc_lo_d;
  logic [N-1:0]  opb_q, opb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N:0]   madd;
  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic         fits;
  logic [N-1:0] step_hi;
  logic [N-1:0] step_lo;

  // Multiply: add multiplicand into the high half when the multiplier LSB is set,
  // then shift the whole {hi, lo} accumulator right.  Divide: shift the next dividend
  // bit into the remainder and subtract the divisor when it fits.
  always_comb begin
    madd    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_hi_q, acc_lo_q[N-1]};
    diff    = shifted - {1'b0, opb_q};
    fits    = ~diff[N];
    if (mode_q == MD_DIV) begin
      step_hi = fits ? diff[N-1:0] : shifted[N-1:0];
      step_lo = {acc_lo_q[N-2:0], fits};
    end else begin
      step_hi = madd[N:1];
      step_lo = {madd[0], acc_lo_q[N-1:1]};
    end
  end

  assign done = run_q && (cnt_q == LAST);
  assign hi   = step_hi;
  assign lo   = step_lo;

  always_comb begin
    run_d    = run_q;
    mode_d   = mode_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    if (start) begin
      run_d    = 1'b1;
      mode_d   = mode;
      acc_hi_d = '0;
      acc_lo_d = (mode == MD_DIV) ? a : b;
      opb_d    = (mode == MD_DIV) ? b : a;
      cnt_d    = '0;
    end else if (run_q) begin
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
      cnt_d    = cnt_q + 1'b1;
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      run_q    <= 1'b0;
      mode_q   <= MD_MUL;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
    end else begin
      run_q    <= run_d;
      mode_q   <= mode_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops computed here,
// MUL/DIV delegated to the iterative alu_muldiv unit; results held until next done.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   SEL,
  output logic [N-1:0] SUM,
  output logic [N-1:0] HI,
  output logic         CarryOut,
  output logic         Zero,
  output logic         Overflow,
  output logic         busy,
  output logic         done
);

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   sel_q, sel_d;
  logic         pend_q, pend_d;
  logic [N-1:0] sum_q, sum_d;
  logic [N-1:0] hi_q, hi_d;
  logic         carry_q, carry_d;
  logic         ovf_q, ovf_d;
  logic         done_q, done_d;

  logic         accept;
  logic         md_start;
  logic         md_mode;
  logic         md_done;
  logic [N-1:0] md_hi;
  logic [N-1:0] md_lo;

  assign busy     = (state_q != ST_IDLE);
  assign accept   = start && !busy;
  // DIV by zero never enters the iterative unit; it completes like a single-cycle op.
  assign md_start = accept && ((SEL == OP_MUL) || ((SEL == OP_DIV) && (B != '0)));
  assign md_mode  = (SEL == OP_DIV) ? MD_DIV : MD_MUL;

  alu_muldiv #(.N(N)) u_muldiv (
    .clk   (clk),
    .srst  (rst),
    .start (md_start),
    .mode  (md_mode),
    .a     (A),
    .b     (B),
    .hi    (md_hi),
    .lo    (md_lo),
    .done  (md_done)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = accept && !md_start;
    a_d     = accept ? A : a_q;
    b_d     = accept ? B : b_q;
    sel_d   = accept ? SEL : sel_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d = (SEL == OP_DIV) ? ST_DIV_RUN : ST_MUL_RUN;
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (md_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [N-1:0] rhs;
  logic [N:0]   add_ext;
  logic [N:0]   sub_ext;
  logic         add_v;
  logic         sub_v;
  logic [N-1:0] alu_sum;
  logic [N-1:0] alu_hi;
  logic         alu_c;
  logic         alu_v;

  // INC/DEC reuse the adder/subtractor with a constant one as right operand.
  always_comb begin
    rhs     = ((sel_q == OP_INC) || (sel_q == OP_DEC)) ? {{(N-1){1'b0}}, 1'b1} : b_q;
    add_ext = {1'b0, a_q} + {1'b0, rhs};
    sub_ext = {1'b0, a_q} - {1'b0, rhs};
    add_v   = (a_q[N-1] == rhs[N-1]) && (add_ext[N-1] != a_q[N-1]);
    sub_v   = (a_q[N-1] != rhs[N-1]) && (sub_ext[N-1] != a_q[N-1]);

    alu_sum = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (sel_q)
      OP_ADD, OP_INC: begin
        alu_sum = add_ext[N-1:0];
        alu_c   = add_ext[N];
        alu_v   = add_v;
      end
      OP_SUB, OP_DEC: begin
        alu_sum = sub_ext[N-1:0];
        alu_c   = ~sub_ext[N];
        alu_v   = sub_v;
      end
      OP_AND: alu_sum = a_q & b_q;
      OP_OR:  alu_sum = a_q | b_q;
      OP_XOR: alu_sum = a_q ^ b_q;
      OP_NOR: alu_sum = ~(a_q | b_q);
      OP_NOT: alu_sum = ~a_q;
      OP_SHL: begin
        alu_sum = {a_q[N-2:0], 1'b0};
        alu_c   = a_q[N-1];
      end
      OP_SHR: begin
        alu_sum = {1'b0, a_q[N-1:1]};
        alu_c   = a_q[0];
      end
      OP_SAR: begin
        alu_sum = {a_q[N-1], a_q[N-1:1]};
        alu_c   = a_q[0];
      end
      OP_ROL: begin
        alu_sum = {a_q[N-2:0], a_q[N-1]};
        alu_c   = a_q[N-1];
      end
      OP_ROR: begin
        alu_sum = {a_q[0], a_q[N-1:1]};
        alu_c   = a_q[0];
      end
      OP_DIV: begin
        alu_sum = '1;
        alu_hi  = a_q;
        alu_v   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sum_d   = sum_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (pend_q) begin
      sum_d   = alu_sum;
      hi_d    = alu_hi;
      carry_d = alu_c;
      ovf_d   = alu_v;
      done_d  = 1'b1;
    end else if (md_done) begin
      sum_d   = md_lo;
      hi_d    = md_hi;
      carry_d = 1'b0;
      ovf_d   = (state_q == ST_MUL_RUN) && (md_hi != '0);
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= OP_ADD;
      pend_q  <= 1'b0;
      sum_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign SUM      = sum_q;
  assign HI       = hi_q;
  assign CarryOut = carry_q;
  assign Overflow = ovf_q;
  assign Zero     = (sum_q == '0);
  assign done     = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (N=8): expected results queued at issue time from an
// integer reference model and compared when done pulses.
module tb_seq_alu;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   SEL;
  logic [N-1:0] SUM;
  logic [N-1:0] HI;
  logic         CarryOut;
  logic         Zero;
  logic         Overflow;
  logic         busy;
  logic         done;

  seq_alu #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .SEL      (SEL),
    .SUM      (SUM),
    .HI       (HI),
    .CarryOut (CarryOut),
    .Zero     (Zero),
    .Overflow (Overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sum;
    logic [7:0] hi;
    logic       c;
    logic       v;
    logic       z;
    int         lat;
    logic [3:0] sel;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   k_cyc = 0;
  int   n_done = 0;
  int   n_exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) n_done++;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    exp_t e;
    int ua, ub, sa, sb_i, r, sr, h;
    ua = a; ub = b; sa = $signed(a); sb_i = $signed(b);
    r = 0; h = 0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.sel = sel;
    case (sel)
      4'd0:  begin r = ua + ub; e.c = (r > 255); sr = sa + sb_i; e.v = (sr > 127) || (sr < -128); end
      4'd1:  begin r = ua - ub; e.c = (ua >= ub); sr = sa - sb_i; e.v = (sr > 127) || (sr < -128); end
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ~(ua | ub);
      4'd6:  r = ~ua;
      4'd7:  begin r = ua * 2; e.c = (ua >= 128); end
      4'd8:  begin r = ua / 2; e.c = (ua % 2) == 1; end
      4'd9:  begin r = sa >>> 1; e.c = (ua % 2) == 1; end
      4'd10: begin r = ((ua * 2) & 255) | (ua / 128); e.c = (ua >= 128); end
      4'd11: begin r = (ua / 2) | ((ua % 2) * 128); e.c = (ua % 2) == 1; end
      4'd12: begin r = ua + 1; e.c = (r > 255); e.v = (sa + 1 > 127); end
      4'd13: begin r = ua - 1; e.c = (ua >= 1); e.v = (sa - 1 < -128); end
      4'd14: begin r = ua * ub; h = r / 256; e.v = (h != 0); e.lat = 8; end
      default: begin
        if (ub == 0) begin r = 255; h = ua; e.v = 1'b1; end
        else begin r = ua / ub; h = ua % ub; e.lat = 8; end
      end
    endcase
    e.sum = r[7:0];
    e.hi  = h[7:0];
    e.z   = (e.sum == 8'h00);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    A = a; B = b; SEL = sel; start = 1'b1;
    sb.push_back(model(a, b, sel));
    @(posedge clk); #1;
    k_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    exp_t e;
    int   i;
    e = sb.pop_front();
    i = 0;
    do begin
      @(posedge clk); #1; i++;
    end while (!(done === 1'b1) && i < 20);
    chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    if (done === 1'b1) begin
      n_exp_done++;
      chk({tag, "_latency"}, cyc - k_cyc, e.lat);
      chk({tag, "_sum"}, {24'b0, SUM}, {24'b0, e.sum});
      chk({tag, "_hi"}, {24'b0, HI}, {24'b0, e.hi});
      chk({tag, "_carry"}, {31'b0, CarryOut}, {31'b0, e.c});
      chk({tag, "_ovf"}, {31'b0, Overflow}, {31'b0, e.v});
      chk({tag, "_zero"}, {31'b0, Zero}, {31'b0, e.z});
      chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      $display("txn %s sel=%0d sum=%h hi=%h c=%b v=%b z=%b lat=%0d",
               tag, e.sel, SUM, HI, CarryOut, Overflow, Zero, cyc - k_cyc);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      chk({tag, "_sum_hold"}, {24'b0, SUM}, {24'b0, e.sum});
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel, input string tag);
    issue(a, b, sel);
    expect_done(tag);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sum"}, {24'b0, SUM}, 32'd0);
    chk({tag, "_hi"}, {24'b0, HI}, 32'd0);
    chk({tag, "_carry"}, {31'b0, CarryOut}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, Overflow}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_zero"}, {31'b0, Zero}, 32'd1);
  endtask

  initial begin
    int d0;
    // Reset with start asserted: reset must win and leave nothing pending.
    rst = 1'b1; start = 1'b1; A = 8'h05; B = 8'h03; SEL = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_overrides_start", {31'b0, done}, 32'd0);

    run(8'h05, 8'h03, 4'd0, "add_5_3");
    run(8'hFF, 8'h01, 4'd0, "add_carry");
    run(8'h7F, 8'h01, 4'd0, "add_ovf");
    run(8'h03, 8'h05, 4'd1, "sub_borrow");
    run(8'h80, 8'h01, 4'd1, "sub_ovf");
    run(8'hFF, 8'h00, 4'd12, "inc_wrap");
    run(8'h00, 8'h00, 4'd13, "dec_wrap");
    run(8'h7F, 8'h00, 4'd12, "inc_ovf");
    run(8'h81, 8'h00, 4'd9, "sar_neg");

    // MUL with operand churn and a stray start while busy.
    issue(8'h10, 8'h20, 4'd14);
    chk("mul_busy_start", {31'b0, busy}, 32'd1);
    A = 8'hFF; B = 8'hFF; SEL = 4'd0; start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("mul_busy_mid", {31'b0, busy}, 32'd1);
    chk("mul_no_early_done", {31'b0, done}, 32'd0);
    start = 1'b0;
    expect_done("mul_10_20");

    run(8'hFF, 8'hFF, 4'd14, "mul_ff_ff");
    run(8'd100, 8'd7, 4'd15, "div_100_7");
    run(8'hFF, 8'h10, 4'd15, "div_ff_10");
    run(8'h2A, 8'h00, 4'd15, "div_by_zero");
    run(8'd100, 8'd7, 4'd15, "div_before_abort");

    // Abort a MUL with reset at the fourth cycle after acceptance.
    issue(8'h33, 8'h44, 4'd14);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("abort");
    void'(sb.pop_back());
    d0 = n_done;
    repeat (12) begin @(posedge clk); #1; end
    chk("abort_no_done", n_done, d0);

    for (int s = 0; s < 14; s++) begin
      run(8'h05, 8'h03, s[3:0], $sformatf("sweep_sel%0d", s));
    end

    chk("done_count", n_done, n_exp_done);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits (legal N >= 2).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 A  input  N  operand A, captured on the edge where start is accepted.
REQ-006 B  input  N  operand B, captured on the edge where start is accepted.
REQ-007 SEL  input  4  opcode, captured on the edge where start is accepted.
REQ-008 SUM  output  N  primary result (low product / quotient for MUL/DIV).
REQ-009 HI  output  N  high product (MUL) / remainder (DIV); 0 for all other ops.
REQ-010 CarryOut  output  1  carry / no-borrow / shifted-out bit.
REQ-011 Zero  output  1  SUM == 0.
REQ-012 Overflow  output  1  signed overflow, MUL high-part nonzero, or DIV by zero.
REQ-013 busy  output  1  operation in progress; start ignored while high.
REQ-014 done  output  1  one-cycle pulse; results valid from this cycle onward.

Function
REQ-015 SEL encoding SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NOT A, 7 SHL A, 8 SHR A (logical), 9 SAR A, 10 ROL A, 11 ROR A, 12 INC A, 13 DEC A, 14 MUL unsigned, 15 DIV unsigned.
REQ-016 Single-cycle ops (0-13): acceptance at edge k; at edge k+1, SUM/HI/flags registered, done=1 for exactly one cycle, busy stays 0.
REQ-017 MUL: shift-add, one bit per cycle; busy=1 from edge k to edge k+N; results and done=1 at edge k+N; {HI,SUM} = A*B (2N bits).
REQ-018 DIV: restoring, one quotient bit per cycle, same timing as MUL; SUM=A/B, HI=A%B.
REQ-019 DIV with B=0: no iteration; at edge k+1, SUM=all ones, HI=A, Overflow=1, done=1, busy=0.
REQ-020 CarryOut: ADD/INC carry out of bit N-1; SUB/DEC 1 when no borrow (A>=B, A>=1); SHL/ROL old A[N-1]; SHR/SAR/ROR old A[0]; 0 otherwise.
REQ-021 Overflow: ADD/SUB/INC/DEC two's-complement signed overflow; MUL HI!=0; DIV B==0; 0 otherwise.
REQ-022 Arithmetic wraps modulo 2^N; INC 0xFF..F -> 0, DEC 0 -> all ones.
REQ-023 FSM states IDLE, MUL_RUN, DIV_RUN; IDLE->MUL_RUN on accepted SEL=14; IDLE->DIV_RUN on accepted SEL=15 with B!=0; RUN->IDLE when iteration count reaches N.
REQ-024 Operands held internally; changes on A/B/SEL while busy=1 have no effect.
REQ-025 start asserted while busy=1 is dropped, not queued; start on the done edge's following cycle is accepted normally.
REQ-026 Outputs hold last result until the next done; no output changes during iteration.

Reset
REQ-027 rst=1 at any edge: state IDLE, SUM=0, HI=0, CarryOut=0, Overflow=0, busy=0, done=0, Zero=1.
REQ-028 rst during MUL_RUN/DIV_RUN aborts; no done is produced for the aborted operation.
REQ-029 rst overrides start on the same edge.

Structure
REQ-030 Shared package alu_pkg SHALL hold the 4-bit opcode constants and the FSM state type.
REQ-031 Iterative datapath SHALL be one sub-module alu_muldiv (operands, mode, start -> {hi, lo}, done); single-cycle ops stay in seq_alu.

Verification (N=8)
REQ-032 ADD A=0x05 B=0x03 -> next cycle SUM=0x08, CarryOut=0, Zero=0, done pulse 1 cycle.
REQ-033 ADD A=0xFF B=0x01 -> SUM=0x00, CarryOut=1, Zero=1; ADD A=0x7F B=0x01 -> SUM=0x80, Overflow=1.
REQ-034 MUL A=0x10 B=0x20 -> busy 8 cycles, then HI=0x02, SUM=0x00, Overflow=1, Zero=1, done pulse.
REQ-035 DIV A=100 B=7 -> SUM=14, HI=2 after 8 cycles; DIV A=0x2A B=0 -> next cycle SUM=0xFF, HI=0x2A, Overflow=1.
REQ-036 MUL started, rst at cycle 4 -> all outputs reset values, no done; second start during busy ignored and produces no second done.
REQ-037 Sweep SEL 0..13 with A=0x05 B=0x03 -> each SUM/CarryOut matches golden model, one done per start.
